mem_datos_arbiter: RTL

//  Shares the single port of the data memory between two requesters: the pipeline MEM stage (CPU) and the debug unit (DBG).

---
 rtl/mem_datos_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_datos_arbiter.sv
// Data-memory port arbiter between the MEM stage (CPU, priority) and the debug unit (DBG).
// DBG gets a forced one-cycle slot, stalling the CPU, once it has been blocked STARVE_LIMIT cycles.
module mem_datos_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  // CPU / MEM stage
  input  logic                  i_cpu_memread,
  input  logic                  i_cpu_memwrite,
  input  logic [DATA_WIDTH-1:0] i_cpu_address,
  input  logic [DATA_WIDTH-1:0] i_cpu_datawrite,
  input  logic                  i_cpu_signed,
  input  logic [1:0]            i_cpu_size,
  output logic [DATA_WIDTH-1:0] o_cpu_dataread,
  output logic                  o_cpu_stall,
  // debug unit
  input  logic                  i_dbg_valid,
  input  logic                  i_dbg_we,
  input  logic [DATA_WIDTH-1:0] i_dbg_address,
  input  logic [DATA_WIDTH-1:0] i_dbg_datawrite,
  input  logic [1:0]            i_dbg_size,
  output logic                  o_dbg_ready,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_dbg_err,
  input  logic                  i_dbg_rready,
  // data memory
  output logic [DATA_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_datawrite,
  output logic                  o_mem_memread,
  output logic                  o_mem_memwrite,
  output logic                  o_mem_signed,
  output logic [1:0]            o_mem_size,
  input  logic [DATA_WIDTH-1:0] i_mem_dataread
);

  localparam logic [CNT_WIDTH-1:0]  LIMIT   = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEM_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic cpu_req;
  logic dbg_oob;
  logic grant;

  assign cpu_req = i_cpu_memread | i_cpu_memwrite;
  assign dbg_oob = (i_dbg_address >= DEPTH_W);
  assign grant   = (state_q == ST_IDLE) & i_dbg_valid & (~cpu_req | (cnt_q == LIMIT));

  // Memory port mux: the CPU owns the port unless DBG is granted this cycle.
  always_comb begin
    o_mem_address   = i_cpu_address;
    o_mem_datawrite = i_cpu_datawrite;
    o_mem_memread   = i_cpu_memread;
    o_mem_memwrite  = i_cpu_memwrite;
    o_mem_signed    = i_cpu_signed;
    o_mem_size      = i_cpu_size;
    o_cpu_stall     = 1'b0;
    o_dbg_ready     = 1'b0;
    if (grant) begin
      o_mem_address   = i_dbg_address;
      o_mem_datawrite = i_dbg_datawrite;
      o_mem_memread   = ~i_dbg_we & ~dbg_oob;
      o_mem_memwrite  = i_dbg_we & ~dbg_oob;
      o_mem_signed    = 1'b0;
      o_mem_size      = i_dbg_size;
      o_cpu_stall     = cpu_req;
      o_dbg_ready     = 1'b1;
    end
  end

  assign o_cpu_dataread = i_mem_dataread;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (state_q == ST_IDLE) begin
      if (grant) begin
        rdata_d  = (~i_dbg_we & ~dbg_oob) ? i_mem_dataread : '0;
        err_d    = dbg_oob;
        rvalid_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_RESP;
      end else if (i_dbg_valid && cpu_req && (cnt_q < LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Response is held until the debug unit takes it.
      if (i_dbg_rready) begin
        rvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_dbg_rvalid = rvalid_q;
  assign o_dbg_rdata  = rdata_q;
  assign o_dbg_err    = err_q;

endmodule
